// File: rtl/alu_issue_seq_if.sv
// alu_issue_seq_if: instruction request and response handshake bundle for the ALU sequencer
interface alu_issue_seq_if #(
  parameter int DATA_W = 8,
  parameter int REG_AW = 3,
  parameter int OPC_W  = 4
);
  logic                      in_valid;
  logic                      in_ready;
  logic [OPC_W+3*REG_AW:0]   in_instr;
  logic                      out_valid;
  logic                      out_ready;
  logic [DATA_W-1:0]         out_result;
  logic [REG_AW-1:0]         out_rd;
  logic [3:0]                status;
  modport master (
    output in_valid, in_instr, out_ready,
    input  in_ready, out_valid, out_result, out_rd, status
  );
  modport slave (
    input  in_valid, in_instr, out_ready,
    output in_ready, out_valid, out_result, out_rd, status
  );
endinterface

// File: rtl/alu_issue_seq.sv
// alu_issue_seq: single-issue sequencer feeding an external ALU from a small register file
module alu_issue_seq #(
  parameter int DATA_W = 8,
  parameter int REG_AW = 3,
  parameter int OPC_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  alu_issue_seq_if.slave    bus,
  input  logic              ld_valid,
  input  logic [REG_AW-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OPC_W-1:0]  alu_opcode,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [3:0]        alu_flags,
  input  logic [REG_AW-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);
  localparam int IW = OPC_W + 3*REG_AW + 1;
  localparam int NR = 2**REG_AW;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;
  logic [1:0]        state;
  logic [REG_AW-1:0] rd;
  logic              wb;
  logic [DATA_W-1:0] regs [NR];
  logic [OPC_W-1:0]  in_op;
  logic [REG_AW-1:0] in_rd, in_rs1, in_rs2;
  logic              in_wb;
  assign {in_op, in_rd, in_rs1, in_rs2, in_wb} = bus.in_instr[IW-1:0];
  assign bus.in_ready  = (state == IDLE) && !rst;
  assign bus.out_valid = (state == RESP);
  assign dbg_data      = regs[dbg_addr];
  // sequencing: operands are registered on accept so the ALU sees a stable cycle in EXEC
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      rd             <= '0;
      wb             <= 1'b0;
      alu_a          <= '0;
      alu_b          <= '0;
      alu_opcode     <= '0;
      bus.out_result <= '0;
      bus.out_rd     <= '0;
      bus.status     <= '0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          state      <= EXEC;
          rd         <= in_rd;
          wb         <= in_wb;
          alu_a      <= regs[in_rs1];
          alu_b      <= regs[in_rs2];
          alu_opcode <= in_op;
        end
        EXEC: begin
          state          <= RESP;
          bus.out_result <= alu_result;
          bus.out_rd     <= rd;
          bus.status     <= alu_flags;
        end
        RESP: if (bus.out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
  // register file: R0 stays zero, writeback is applied after preload so it wins on a collision
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NR; i++) regs[i] <= '0;
    end else begin
      regs[0] <= '0;
      for (int i = 1; i < NR; i++) begin
        if (ld_valid && ld_addr == REG_AW'(i)) regs[i] <= ld_data;
        if (state == EXEC && wb && rd == REG_AW'(i)) regs[i] <= alu_result;
      end
    end
  end
endmodule

// File: tb/tb_alu_issue_seq.sv
// tb_alu_issue_seq: scoreboard bench with a behavioural ALU attached to the sequencer
module tb_alu_issue_seq;
  logic       clk = 0;
  logic       rst;
  logic       ld_valid;
  logic [2:0] ld_addr;
  logic [7:0] ld_data;
  logic [7:0] alu_a, alu_b, alu_result;
  logic [3:0] alu_opcode, alu_flags;
  logic [2:0] dbg_addr;
  logic [7:0] dbg_data;
  int n_tests = 0;
  int n_fail = 0;
  typedef struct packed {
    logic [7:0] r;
    logic [2:0] rd;
    logic [3:0] f;
  } exp_t;
  exp_t sbq[$];
  logic [7:0] mregs [8];
  alu_issue_seq_if #(.DATA_W(8), .REG_AW(3), .OPC_W(4)) bus ();
  alu_issue_seq #(.DATA_W(8), .REG_AW(3), .OPC_W(4)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
    .alu_result(alu_result), .alu_flags(alu_flags),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );
  always #5 clk = ~clk;
  function automatic logic [11:0] alu_fn(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    logic [7:0] r;
    logic c, v;
    c = 1'b0;
    v = 1'b0;
    r = 8'h00;
    case (op)
      4'd0: begin
        s = {1'b0, a} + {1'b0, b};
        r = s[7:0];
        c = s[8];
        v = (a[7] == b[7]) && (r[7] != a[7]);
      end
      4'd1: begin
        r = a - b;
        c = a < b;
        v = (a[7] != b[7]) && (r[7] != a[7]);
      end
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd14: r = ($signed(a) > $signed(b)) ? 8'h01 : 8'h00;
      default: r = 8'h00;
    endcase
    return {r, c, r == 8'h00, v, r[7]};
  endfunction
  assign {alu_result, alu_flags} = alu_fn(alu_opcode, alu_a, alu_b);
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic preload(input logic [2:0] a, input logic [7:0] d);
    @(negedge clk);
    ld_valid = 1;
    ld_addr  = a;
    ld_data  = d;
    @(negedge clk);
    ld_valid = 0;
    if (a != 0) mregs[a] = d;
  endtask
  task automatic dbg_chk(input string tag, input logic [2:0] a, input logic [7:0] d);
    dbg_addr = a;
    #1;
    check(tag, dbg_data, d);
  endtask
  task automatic issue(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                       input logic [2:0] rs2, input logic wb, input logic pl_en,
                       input logic [2:0] pl_a, input logic [7:0] pl_d, input int hold);
    int t;
    exp_t e;
    logic [11:0] o;
    @(negedge clk);
    bus.in_valid = 1;
    bus.in_instr = {op, rd, rs1, rs2, wb};
    t = 0;
    while (!bus.in_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("accept_timeout", t < 20, 1);
    o = alu_fn(op, mregs[rs1], mregs[rs2]);
    e.r = o[11:4];
    e.rd = rd;
    e.f = o[3:0];
    sbq.push_back(e);
    @(posedge clk);
    #1;
    bus.in_valid = 0;
    check("exec_out_valid", bus.out_valid, 0);
    check("exec_in_ready", bus.in_ready, 0);
    check("alu_a", alu_a, mregs[rs1]);
    check("alu_b", alu_b, mregs[rs2]);
    check("alu_opcode", alu_opcode, op);
    if (pl_en) begin
      ld_valid = 1;
      ld_addr  = pl_a;
      ld_data  = pl_d;
    end
    @(posedge clk);
    #1;
    ld_valid = 0;
    if (pl_en && pl_a != 0) mregs[pl_a] = pl_d;
    if (wb && rd != 0) mregs[rd] = e.r;
    check("latency_out_valid", bus.out_valid, 1);
    for (int i = 0; i < hold; i++) begin
      bus.in_valid = 1;
      bus.in_instr = 14'($urandom);
      @(posedge clk);
      #1;
      check("hold_out_valid", bus.out_valid, 1);
      check("hold_in_ready", bus.in_ready, 0);
      check("hold_result", bus.out_result, e.r);
      check("hold_status", bus.status, e.f);
    end
    bus.in_valid = 0;
    bus.out_ready = 1;
    e = sbq.pop_front();
    check("out_result", bus.out_result, e.r);
    check("out_rd", bus.out_rd, e.rd);
    check("status", bus.status, e.f);
    @(posedge clk);
    #1;
    bus.out_ready = 0;
    check("post_out_valid", bus.out_valid, 0);
    check("post_in_ready", bus.in_ready, 1);
  endtask
  initial begin
    rst = 1;
    ld_valid = 0;
    ld_addr = 0;
    ld_data = 0;
    dbg_addr = 0;
    bus.in_valid = 0;
    bus.in_instr = '0;
    bus.out_ready = 0;
    for (int i = 0; i < 8; i++) mregs[i] = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_result", bus.out_result, 0);
    check("rst_status", bus.status, 0);
    check("rst_alu_a", alu_a, 0);
    @(negedge clk);
    rst = 0;
    #1;
    check("rst_in_ready", bus.in_ready, 1);
    preload(3'd1, 8'h7F);
    preload(3'd2, 8'h01);
    issue(4'd0, 3'd3, 3'd1, 3'd2, 1'b1, 1'b0, 3'd0, 8'h00, 0);
    dbg_chk("add_r3", 3'd3, 8'h80);
    issue(4'd1, 3'd4, 3'd1, 3'd1, 1'b1, 1'b0, 3'd0, 8'h00, 0);
    dbg_chk("sub_r4", 3'd4, 8'h00);
    issue(4'd14, 3'd5, 3'd1, 3'd2, 1'b0, 1'b0, 3'd0, 8'h00, 5);
    dbg_chk("cmpgt_r5", 3'd5, 8'h00);
    issue(4'd1, 3'd6, 3'd1, 3'd2, 1'b1, 1'b0, 3'd0, 8'h00, 0);
    dbg_chk("sub_r6", 3'd6, 8'h7E);
    issue(4'd0, 3'd0, 3'd1, 3'd2, 1'b1, 1'b0, 3'd0, 8'h00, 0);
    preload(3'd0, 8'hFF);
    dbg_chk("r0_zero", 3'd0, 8'h00);
    preload(3'd7, 8'h55);
    issue(4'd3, 3'd3, 3'd7, 3'd0, 1'b1, 1'b1, 3'd3, 8'hAA, 0);
    dbg_chk("wb_wins", 3'd3, 8'h55);
    issue(4'd0, 3'd2, 3'd1, 3'd2, 1'b1, 1'b1, 3'd1, 8'h10, 1);
    dbg_chk("exec_preload_r1", 3'd1, 8'h10);
    dbg_chk("exec_preload_r2", 3'd2, 8'h80);
    for (int k = 0; k < 12; k++) begin
      logic [3:0] op;
      logic [2:0] sel;
      sel = 3'($urandom_range(0, 5));
      op = (sel == 3'd5) ? 4'd14 : {1'b0, sel};
      issue(op, 3'($urandom), 3'($urandom), 3'($urandom), 1'($urandom), 1'($urandom),
            3'($urandom), 8'($urandom), $urandom_range(0, 2));
    end
    for (int i = 0; i < 8; i++) dbg_chk("regfile", 3'(i), mregs[i]);
    preload(3'd1, 8'h33);
    @(negedge clk);
    bus.in_valid = 1;
    bus.in_instr = {4'd0, 3'd6, 3'd1, 3'd1, 1'b1};
    @(posedge clk);
    #1;
    bus.in_valid = 0;
    check("pre_rst_alu_a", alu_a, 8'h33);
    #2;
    rst = 1;
    #1;
    check("arst_out_valid", bus.out_valid, 0);
    check("arst_out_result", bus.out_result, 0);
    check("arst_out_rd", bus.out_rd, 0);
    check("arst_status", bus.status, 0);
    check("arst_alu_a", alu_a, 0);
    check("arst_alu_b", alu_b, 0);
    check("arst_alu_opcode", alu_opcode, 0);
    for (int i = 0; i < 8; i++) dbg_chk("arst_regs", 3'(i), 8'h00);
    for (int i = 0; i < 8; i++) mregs[i] = 8'h00;
    @(negedge clk);
    rst = 0;
    #1;
    check("arst_in_ready", bus.in_ready, 1);
    repeat (3) @(posedge clk);
    #1;
    check("arst_no_resp", bus.out_valid, 0);
    dbg_chk("arst_no_wb", 3'd6, 8'h00);
    issue(4'd4, 3'd2, 3'd0, 3'd0, 1'b1, 1'b0, 3'd0, 8'h00, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
